// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder with a small control FSM. One addition
//   {carry_out, sum_out} = a_in + b_in + cin_in is computed through a single
//   1-bit full-add cell and a carry flip-flop, one bit per clock, LSB first.
//
//   Timing: a start accepted at edge 0 runs on edges 1..WIDTH. done_out is high
//   for the cycle after edge WIDTH, and the block is idle again after edge
//   WIDTH+1, so back-to-back starts are WIDTH+2 cycles apart.
//
// Ports
//   clk_in     : clock, all state changes on the rising edge
//   rstn_in    : synchronous active-low reset
//   start_in   : start request, only looked at in IDLE
//   a_in, b_in : operands, captured on the accepting edge
//   cin_in     : carry-in, captured on the accepting edge
//   busy_out   : high in RUN and DONE
//   done_out   : one-cycle completion pulse (DONE state)
//   sum_out    : registered result sum, held until the next completion
//   carry_out  : registered result carry, held until the next completion
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             sum_bit;
  logic [1:0]       fa;

  // One-bit full adder: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic m;
    s = x ^ y ^ c;
    m = (x & y) | (x & c) | (y & c);
    return {m, s};
  endfunction

  // Datapath next-state: one full-add step and the shifts that go with it.
  // Whole-vector shifts are used so every register bit is consumed; the sum
  // bit enters the result register from the MSB side, so after WIDTH steps
  // the first (LSB) sum bit has reached bit 0.
  always_comb begin
    fa      = full_add(a_q[0], b_q[0], carry_q);
    sum_bit = fa[0];
    carry_d = fa[1];
    a_d     = a_q >> 1;
    b_d     = b_q >> 1;
    res_d   = (res_q >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // The edge that processes the MSB publishes the result directly
          // from the next-state values, so no extra cycle is spent.
          if (cnt_q == LAST_BIT) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): table of operations applied in a
// loop with a scoreboard queue of expected results, plus hand-written
// sequences for held start, mid-run reset and first-edge-after-reset start.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk_in;
  logic         rstn_in;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         carry_out;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .rstn_in  (rstn_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .sum_out  (sum_out),
    .carry_out(carry_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         scramble;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] last_sum;
  logic         last_carry;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation and follow it to completion.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic scr, input logic [W-1:0] es, input logic ec,
                       input logic rel);
    logic [W:0] e;
    bit         got;
    @(negedge clk_in);
    if (rel) rstn_in = 1'b1;
    a_in     = a;
    b_in     = b;
    cin_in   = cin;
    start_in = 1'b1;
    exp_q.push_back({ec, es});
    @(posedge clk_in); #1;
    check("busy_at_accept", {31'd0, busy_out}, 32'd1);
    check("done_at_accept", {31'd0, done_out}, 32'd0);
    @(negedge clk_in);
    start_in = 1'b0;
    if (scr) begin
      a_in   = '0;
      b_in   = ~b;
      cin_in = ~cin;
    end
    got = 0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(posedge clk_in); #1;
      if (done_out) begin
        got = 1;
        check("latency", cyc, 32'd8);
        check("busy_in_done", {31'd0, busy_out}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got done pulse, expected no pulse");
        end else begin
          e = exp_q.pop_front();
          check("sum", {24'd0, sum_out}, {24'd0, e[W-1:0]});
          check("carry", {31'd0, carry_out}, {31'd0, e[W]});
          last_sum   = e[W-1:0];
          last_carry = e[W];
        end
      end else if (cyc < 8) begin
        check("busy_in_run", {31'd0, busy_out}, 32'd1);
        check("sum_hold_run", {24'd0, sum_out}, {24'd0, last_sum});
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse in 20 cycles, expected one at cycle 8");
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end
    @(posedge clk_in); #1;
    check("done_cleared", {31'd0, done_out}, 32'd0);
    check("busy_cleared", {31'd0, busy_out}, 32'd0);
    check("sum_hold_idle", {24'd0, sum_out}, {24'd0, last_sum});
    check("carry_hold_idle", {31'd0, carry_out}, {31'd0, last_carry});
  endtask

  initial begin
    logic [W:0] m;
    int         pulses;

    rstn_in    = 1'b0;
    start_in   = 1'b0;
    a_in       = 8'hA5;
    b_in       = 8'h5A;
    cin_in     = 1'b1;
    last_sum   = '0;
    last_carry = 1'b0;

    // Directed entries with hand-computed results, then random ones.
    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, scramble: 1'b0, exp_sum: 8'h00, exp_carry: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, scramble: 1'b0, exp_sum: 8'h00, exp_carry: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, scramble: 1'b0, exp_sum: 8'hFF, exp_carry: 1'b1};
    vecs[3] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, scramble: 1'b1, exp_sum: 8'hFF, exp_carry: 1'b0};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].a        = W'($urandom_range(0, 255));
      vecs[i].b        = W'($urandom_range(0, 255));
      vecs[i].cin      = 1'($urandom_range(0, 1));
      vecs[i].scramble = 1'(i % 2);
      m = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {{W{1'b0}}, vecs[i].cin};
      vecs[i].exp_sum   = m[W-1:0];
      vecs[i].exp_carry = m[W];
    end

    // Reset state.
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_sum", {24'd0, sum_out}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);

    // First op releases reset on the same edge that starts it.
    for (int i = 0; i < NVEC; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].scramble,
            vecs[i].exp_sum, vecs[i].exp_carry, (i == 0));

    // start_in held high: a pulse every 10 cycles, each with 0x46.
    pulses = 0;
    @(negedge clk_in);
    a_in     = 8'h12;
    b_in     = 8'h34;
    cin_in   = 1'b0;
    start_in = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk_in); #1;
      if (done_out) begin
        pulses++;
        check("held_pulse_pos", cyc % 10, 32'd8);
        check("held_sum", {24'd0, sum_out}, 32'h46);
        check("held_carry", {31'd0, carry_out}, 32'd0);
      end
      if (cyc == 31) begin
        @(negedge clk_in);
        start_in = 1'b0;
      end
    end
    check("held_pulse_count", pulses, 32'd4);
    last_sum   = 8'h46;
    last_carry = 1'b0;

    // Reset on the 4th RUN edge aborts the operation.
    @(negedge clk_in);
    a_in     = 8'hF0;
    b_in     = 8'h33;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    check("abort_busy_accept", {31'd0, busy_out}, 32'd1);
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rstn_in = 1'b0;
    @(posedge clk_in); #1;
    check("abort_busy", {31'd0, busy_out}, 32'd0);
    check("abort_sum", {24'd0, sum_out}, 32'd0);
    check("abort_carry", {31'd0, carry_out}, 32'd0);
    check("abort_done", {31'd0, done_out}, 32'd0);
    last_sum   = '0;
    last_carry = 1'b0;
    @(negedge clk_in);
    rstn_in = 1'b1;
    pulses  = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk_in); #1;
      if (done_out || busy_out) pulses++;
    end
    check("abort_no_activity", pulses, 32'd0);
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the operand width in bits; legal values are 2..32.
REQ-002 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 rstn_in  input  1  reset, synchronous and active-low.
REQ-004 start_in  input  1  request to start one addition; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b_in  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 cin_in  input  1  carry-in; captured on the accepting edge.
REQ-008 busy_out  output  1  high in RUN and DONE.
REQ-009 done_out  output  1  single-cycle completion pulse.
REQ-010 sum_out  output  WIDTH  result sum bits, registered.
REQ-011 carry_out  output  1  result carry, registered.

Function
REQ-012 The block SHALL compute {carry_out, sum_out} = a_in + b_in + cin_in exactly, modulo 2^(WIDTH+1).
REQ-013 The arithmetic SHALL be bit-serial through a single 1-bit full-add cell with a carry flip-flop, processing one bit per clock, LSB first.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE, all encoded in registers.
REQ-015 IDLE SHALL transition to RUN on any edge where start_in=1; that edge loads the A and B shift registers, loads the carry flip-flop with cin_in, and clears the bit counter.
REQ-016 On each RUN edge the block SHALL:
- form sum bit = A[0]^B[0]^carry;
- form new carry = majority(A[0], B[0], carry);
- shift the sum bit into an internal result register from the MSB side;
- shift A and B right by one;
- increment the counter.
REQ-017 RUN SHALL transition to DONE on the edge that processes bit WIDTH-1, i.e. the WIDTH-th RUN edge.
REQ-018 On that same edge sum_out and carry_out SHALL load the final result; they SHALL NOT change at any other time except reset.
REQ-019 DONE SHALL last exactly one cycle, with done_out=1 during it, then return unconditionally to IDLE.
REQ-020 Latency: if start_in is accepted at edge 0, done_out SHALL be high for the one cycle following edge WIDTH, and IDLE SHALL resume after edge WIDTH+1.
REQ-021 Minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-022 start_in SHALL be ignored in RUN and DONE; no queuing and no effect on the operation in flight.
REQ-023 Changes on a_in, b_in or cin_in after the accepting edge SHALL have no effect on the current result.
REQ-024 busy_out SHALL be 0 in IDLE and 1 in RUN and DONE; done_out SHALL be 0 outside DONE.
REQ-025 sum_out and carry_out SHALL hold the last result indefinitely while in IDLE.

Reset
REQ-026 On any rising edge with rstn_in=0 the block SHALL:
- enter IDLE;
- clear busy_out, done_out, sum_out, carry_out, the counter, the shift registers and the carry flip-flop to 0.
REQ-027 Reset SHALL take priority over start_in and over any in-flight operation; an aborted operation SHALL produce no done_out pulse.
REQ-028 The first start_in SHALL be accepted on the first edge with rstn_in=1.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, cin=0, one-cycle start -> done_out pulse 8 cycles after accept; sum_out=0x00, carry_out=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum_out=0x00, carry_out=1; busy_out high for exactly 9 cycles.
REQ-031 a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, carry_out=1.
REQ-032 a=0x55, b=0xAA, cin=0; a_in forced to 0x00 on the cycle after accept -> sum_out=0xFF, carry_out=0.
REQ-033 start_in held high continuously, a=0x12, b=0x34 -> done_out pulses every 10 cycles, each time with sum_out=0x46; no extra pulses.
REQ-034 rstn_in=0 for one edge during the 4th RUN cycle -> busy_out=0, sum_out=0x00, no done_out. Then a=0x0F, b=0x01 start -> sum_out=0x10, carry_out=0.
